// File: rtl/instr_fetch.sv
// Instruction fetch stage: owns the PC, issues single-outstanding imem requests and
// presents each fetched word to decode until it is consumed.
module instr_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic             imem_req,
    output logic [31:0]      imem_addr,
    input  logic             imem_ack,
    input  logic [31:0]      imem_rdata,
    input  logic             stall,
    input  logic             jump,
    input  logic             jump_reg,
    input  logic [31:0]      reg_target,
    input  logic             branch,
    input  logic             zero,
    output logic             if_valid,
    output logic [31:0]      if_instr,
    output logic [5:0]       if_opcode,
    output logic [5:0]       if_funct,
    output logic [31:0]      if_pc,
    output logic [31:0]      if_pc_plus4,
    output logic             addr_err,
    output logic [CNT_W-1:0] fetch_count
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FETCH = 2'd1;
    localparam logic [1:0] ST_HOLD  = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [31:0]      pc_q, pc_d;
    logic [31:0]      if_instr_q;
    logic [31:0]      if_pc_q;
    logic [CNT_W-1:0] fetch_count_q;
    logic             capture;
    logic             consume;
    logic [31:0]      pc_plus4;
    logic [31:0]      branch_off;

    // Data is only taken while a request is outstanding, so stray or late acks are dropped.
    assign capture    = (state_q == ST_FETCH) && imem_ack;
    assign consume    = (state_q == ST_HOLD) && !stall;
    assign pc_plus4   = if_pc_q + 32'd4;
    assign branch_off = {{14{if_instr_q[15]}}, if_instr_q[15:0], 2'b00};

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  state_d = ST_FETCH;
            ST_FETCH: if (imem_ack) state_d = ST_HOLD;
            ST_HOLD:  if (!stall) state_d = ST_FETCH;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        pc_d = pc_q;
        if (consume) begin
            if (jump && jump_reg) begin
                pc_d = {reg_target[31:2], 2'b00};
            end else if (jump) begin
                pc_d = {pc_plus4[31:28], if_instr_q[25:0], 2'b00};
            end else if (branch && zero) begin
                pc_d = pc_plus4 + branch_off;
            end else begin
                pc_d = pc_plus4;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            pc_q          <= RESET_PC;
            if_instr_q    <= 32'h0;
            if_pc_q       <= RESET_PC;
            fetch_count_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            if (capture) begin
                if_instr_q <= imem_rdata;
                if_pc_q    <= pc_q;
            end
            if (consume) begin
                fetch_count_q <= fetch_count_q + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    assign imem_req    = (state_q == ST_FETCH);
    assign imem_addr   = pc_q;
    assign if_valid    = (state_q == ST_HOLD);
    assign if_instr    = if_instr_q;
    assign if_opcode   = if_instr_q[31:26];
    assign if_funct    = if_instr_q[5:0];
    assign if_pc       = if_pc_q;
    assign if_pc_plus4 = pc_plus4;
    // Flags a misaligned register-jump target during the consume cycle only.
    assign addr_err    = consume && jump && jump_reg && (reg_target[1:0] != 2'b00);
    assign fetch_count = fetch_count_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: a memory responder feeds words, a scoreboard of
// expected addresses and presented instructions is checked against the DUT.
module tb_instr_fetch;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        stall;
    logic        jump;
    logic        jump_reg;
    logic [31:0] reg_target;
    logic        branch;
    logic        zero;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [5:0]  if_opcode;
    logic [5:0]  if_funct;
    logic [31:0] if_pc;
    logic [31:0] if_pc_plus4;
    logic        addr_err;
    logic [31:0] fetch_count;

    int n_cmp = 0;
    int n_err = 0;
    int model_count = 0;

    logic [31:0] exp_addr_q[$];
    logic [31:0] exp_instr_q[$];
    logic [31:0] exp_pc_q[$];

    always #5 clk = ~clk;

    instr_fetch #(
        .RESET_PC(32'h0000_0000),
        .CNT_W   (32)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .stall      (stall),
        .jump       (jump),
        .jump_reg   (jump_reg),
        .reg_target (reg_target),
        .branch     (branch),
        .zero       (zero),
        .if_valid   (if_valid),
        .if_instr   (if_instr),
        .if_opcode  (if_opcode),
        .if_funct   (if_funct),
        .if_pc      (if_pc),
        .if_pc_plus4(if_pc_plus4),
        .addr_err   (addr_err),
        .fetch_count(fetch_count)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic clear_ctrl();
        jump       = 1'b0;
        jump_reg   = 1'b0;
        reg_target = 32'h0;
        branch     = 1'b0;
        zero       = 1'b0;
    endtask

    // Waits for a request, holds ack off for 'delay' cycles, then returns 'instr'.
    task automatic do_fetch(input int delay, input logic [31:0] instr);
        int          n;
        logic [31:0] ea, ei, ep;
        n = 0;
        while (imem_req !== 1'b1 && n < 8) begin
            @(negedge clk);
            n++;
        end
        check("req_seen", {31'h0, imem_req}, 32'h1);
        ea = (exp_addr_q.size() > 0) ? exp_addr_q.pop_front() : 32'hxxxx_xxxx;
        check("imem_addr", imem_addr, ea);
        for (int i = 0; i < delay; i++) begin
            imem_ack   = 1'b0;
            imem_rdata = 32'hxxxx_xxxx;
            @(negedge clk);
            check("addr_hold", imem_addr, ea);
            check("req_hold", {31'h0, imem_req}, 32'h1);
            check("valid_wait", {31'h0, if_valid}, 32'h0);
        end
        imem_ack   = 1'b1;
        imem_rdata = instr;
        exp_instr_q.push_back(instr);
        exp_pc_q.push_back(ea);
        @(negedge clk);
        imem_ack   = 1'b0;
        imem_rdata = 32'hxxxx_xxxx;
        ei = exp_instr_q.pop_front();
        ep = exp_pc_q.pop_front();
        check("if_valid", {31'h0, if_valid}, 32'h1);
        check("req_low_hold", {31'h0, imem_req}, 32'h0);
        check("if_instr", if_instr, ei);
        check("if_opcode", {26'h0, if_opcode}, {26'h0, ei[31:26]});
        check("if_funct", {26'h0, if_funct}, {26'h0, ei[5:0]});
        check("if_pc", if_pc, ep);
        check("if_pc_plus4", if_pc_plus4, ep + 32'd4);
        exp_instr_q.push_back(ei);
        exp_pc_q.push_back(ep);
    endtask

    // Stalls for 'holds' cycles with noisy control, then consumes with the given decision.
    task automatic consume(input int holds, input logic j, input logic jr, input logic [31:0] rt,
                           input logic b, input logic z, input logic [31:0] exp_next,
                           input logic exp_err);
        logic [31:0] ei, ep;
        ei = exp_instr_q.pop_front();
        ep = exp_pc_q.pop_front();
        for (int i = 0; i < holds; i++) begin
            stall      = 1'b1;
            jump       = 1'b1;
            jump_reg   = 1'b1;
            reg_target = 32'h0000_0003;
            branch     = 1'b1;
            zero       = 1'b1;
            @(negedge clk);
            check("stall_valid", {31'h0, if_valid}, 32'h1);
            check("stall_instr", if_instr, ei);
            check("stall_pc", if_pc, ep);
            check("stall_count", fetch_count, model_count);
            check("stall_err", {31'h0, addr_err}, 32'h0);
        end
        stall      = 1'b0;
        jump       = j;
        jump_reg   = jr;
        reg_target = rt;
        branch     = b;
        zero       = z;
        #1;
        check("addr_err", {31'h0, addr_err}, {31'h0, exp_err});
        model_count++;
        exp_addr_q.push_back(exp_next);
        @(negedge clk);
        stall = 1'b1;
        clear_ctrl();
        check("valid_drop", {31'h0, if_valid}, 32'h0);
        check("fetch_count", fetch_count, model_count);
        check("err_gone", {31'h0, addr_err}, 32'h0);
    endtask

    initial begin
        rst_n      = 1'b0;
        imem_ack   = 1'b0;
        imem_rdata = 32'hxxxx_xxxx;
        stall      = 1'b1;
        clear_ctrl();
        repeat (2) @(negedge clk);
        check("rst_req", {31'h0, imem_req}, 32'h0);
        check("rst_addr", imem_addr, 32'h0);
        check("rst_valid", {31'h0, if_valid}, 32'h0);
        check("rst_instr", if_instr, 32'h0);
        check("rst_pc", if_pc, 32'h0);
        check("rst_err", {31'h0, addr_err}, 32'h0);
        check("rst_count", fetch_count, 32'h0);
        rst_n = 1'b1;
        #1;
        check("idle_req", {31'h0, imem_req}, 32'h0);
        exp_addr_q.push_back(32'h0);
        @(negedge clk);

        // Sequential stream with same-cycle acks
        do_fetch(0, 32'h0000_0001);
        consume(0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0000_0004, 1'b0);
        do_fetch(0, 32'h0000_0002);
        consume(0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0000_0008, 1'b0);
        do_fetch(0, 32'h2000_0003);
        consume(0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0000_000C, 1'b0);
        // Slow memory plus decode stall
        do_fetch(3, 32'h0400_0005);
        consume(2, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0000_0010, 1'b0);
        do_fetch(0, 32'h0000_0008);
        consume(0, 1'b1, 1'b1, 32'h0000_0100, 1'b0, 1'b0, 32'h0000_0100, 1'b0);
        // Backward branch to self, then not-taken
        do_fetch(1, 32'h1000_FFFF);
        consume(0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h0000_0100, 1'b0);
        do_fetch(0, 32'h1000_FFFF);
        consume(0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0000_0104, 1'b0);
        do_fetch(0, 32'h0000_0008);
        consume(0, 1'b1, 1'b1, 32'h4000_0000, 1'b0, 1'b0, 32'h4000_0000, 1'b0);
        // J-format keeps the upper nibble of pc+4
        do_fetch(0, 32'h0800_0040);
        consume(0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h4000_0100, 1'b0);
        do_fetch(2, 32'h0000_0008);
        consume(0, 1'b1, 1'b1, 32'h0000_2002, 1'b0, 1'b0, 32'h0000_2000, 1'b1);
        // Register jump outranks a taken branch
        do_fetch(0, 32'h1000_0004);
        consume(1, 1'b1, 1'b1, 32'hFFFF_FFFC, 1'b1, 1'b1, 32'hFFFF_FFFC, 1'b0);
        // PC wraps to zero
        do_fetch(0, 32'h0800_0001);
        consume(0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0000_0000, 1'b0);
        do_fetch(0, 32'h1000_0002);
        consume(0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'h0000_000C, 1'b0);

        // Reset while a request is outstanding; a late ack must be dropped
        check("pre_rst_req", {31'h0, imem_req}, 32'h1);
        check("pre_rst_addr", imem_addr, 32'h0000_000C);
        rst_n = 1'b0;
        #1;
        check("mid_rst_req", {31'h0, imem_req}, 32'h0);
        check("mid_rst_addr", imem_addr, 32'h0);
        check("mid_rst_count", fetch_count, 32'h0);
        check("mid_rst_valid", {31'h0, if_valid}, 32'h0);
        check("mid_rst_instr", if_instr, 32'h0);
        exp_addr_q.delete();
        exp_instr_q.delete();
        exp_pc_q.delete();
        model_count = 0;
        @(negedge clk);
        rst_n      = 1'b1;
        imem_ack   = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        #1;
        check("rel_idle_req", {31'h0, imem_req}, 32'h0);
        @(negedge clk);
        imem_ack   = 1'b0;
        imem_rdata = 32'hxxxx_xxxx;
        check("late_ack_valid", {31'h0, if_valid}, 32'h0);
        check("late_ack_instr", if_instr, 32'h0);
        exp_addr_q.push_back(32'h0);
        do_fetch(0, 32'h1234_5678);
        consume(0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0000_0004, 1'b0);
        check("final_req", {31'h0, imem_req}, 32'h1);
        check("final_addr", imem_addr, exp_addr_q.pop_front());

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
